frame_cmd_scheduler: RTL and testbench
======================================

Name: frame_cmd_scheduler

Overview:
- Upstream stage of every display layer (ground, sprites, background) in the VGA peripheral: owns the shared 32-bit command bus that each layer decodes.
- Accepts Avalon-MM writes from software, queues them and stamps each command with the current back-buffer index before driving it onto the layer command bus.
- On a software commit, issues exactly one buffer-swap command per vertical blank, so software never tears the displayed frame.

Parameters:
- FIFO_DEPTH, 64, command queue entries (power of two).
- V_ACTIVE, 10'd480, first vcount line of vertical blank.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- chipselect  in  1  Avalon slave select
- write  in  1  Avalon write strobe
- read  in  1  Avalon read strobe
- address  in  2  register select: 0 command, 1 commit, 2 clear overflow
- writedata  in  32  Avalon write data
- readdata  out  32  status word
- vcount  in  10  current VGA line
- cmd_out  out  32  layer command bus, feeds writedata of every layer
- back_buf  out  1  current back-buffer index

Behaviour:
- Command word fields on the layer bus:
  - [31:26] sub_comp, [25:21] child, [20:17] info, [16:14] input_type, [13] buffer_state, [12:0] msg.
  - Layers act only on info 4'b0001 (update) and 4'b1111 (swap).
  - Idle word is 32'h0 (info 0000, no effect on any layer).
- Reset (async) clears the FIFO, sets level to 0, cmd_out to 0, back_buf to 1, overflow to 0 and swapped_this_blank to 0.
- Avalon accesses:
  - Write, address 0: enqueue {marker=0, writedata}.
  - Write, address 1: enqueue {marker=1, 32'h0} (commit); writedata is ignored.
  - Write, address 2: clear overflow.
  - Address 3 writes are ignored.
  - Reads are combinational (0 wait states): readdata = {8'h0, level[15:0] zero-extended, 5'h0, overflow, commit_pending, back_buf}.
  - commit_pending = a marker entry exists anywhere in the FIFO.
- Full handling:
  - An enqueue while full (evaluated before the edge) is dropped and sets overflow (sticky).
  - A simultaneous pop does not rescue a write that was full before the edge.
- Drain, one entry per cycle, first-word fall-through; cmd_out is registered:
  - Head non-marker: pop and drive {w[31:21], info', w[16:14], back_buf, w[12:0]} for exactly one cycle. info' is w[20:17], forced to 4'b0000 when it equals 4'b1111 (software cannot swap directly).
  - Head marker: hold without popping while NOT (vcount >= V_ACTIVE and swapped_this_blank==0). Once the condition holds, pop, drive 32'h001E0000 | (back_buf<<13) for one cycle, toggle back_buf and set swapped_this_blank.
  - Entries behind a marker never drain before that marker's swap.
  - FIFO empty: cmd_out = 32'h0.
- swapped_this_blank clears on any cycle with vcount < V_ACTIVE, which limits the design to at most one swap per blank.
- Latency: a write at edge N to an empty, unblocked FIFO appears on cmd_out after edge N+1. A simultaneous enqueue and pop leaves level unchanged.
- An async reset mid-frame discards all queued commands, including any pending commit.

Decomposition:
- Package frame_cmd_pkg holds:
  - Field bit positions.
  - INFO_UPDATE=4'b0001, INFO_SWAP=4'b1111, IDLE_CMD=32'h0.
  - Register address constants ADDR_CMD=0, ADDR_COMMIT=1, ADDR_CLR=2.
  - The 33-bit fifo entry struct {marker, word}.
- Sub-module cmd_fifo: 33-bit synchronous FIFO with async reset and outputs full, empty, level and head. FIFO_DEPTH is passed through as a parameter.

Test Plan:
- Reset -> cmd_out=0, readdata=32'h00000001 (back_buf=1, level 0, no overflow).
- vcount=100, write addr0 0x3C0280C8 -> cmd_out=0x3C02A0C8 one cycle after the write edge, 0 on the next cycle.
- vcount=100, write addr1 (commit) -> cmd_out stays 0 and status bit1=1. When vcount steps to 480 -> cmd_out=0x001E2000 for one cycle, then back_buf=0 and status bit1=0.
- Commit then write 0x3C0280C8, both at vcount=100 -> no output until vcount=480. Then 0x001E2000 appears, followed next cycle by 0x3C0280C8 stamped with bit13=0.
- Two commits at vcount=100 -> first swap at vcount=480 of frame k (word 0x001E2000). Second swap only after vcount<480 and then 480 again (word 0x001E0000). back_buf returns to 1.
- Commit then 64 command writes at vcount=100 -> level=64, last write dropped, status overflow=1. Write addr2 -> overflow=0. A command word with info 1111 is emitted with info 0000.

Source files
------------

// File: rtl/frame_cmd_pkg.sv
// Shared definitions for the frame command scheduler: layer command word
// field positions, info codes, register addresses, the FIFO entry layout
// and the word-building helpers.
package frame_cmd_pkg;

    localparam int unsigned CMD_W          = 32;
    localparam int unsigned SUB_COMP_LSB   = 26;
    localparam int unsigned CHILD_LSB      = 21;
    localparam int unsigned INFO_MSB       = 20;
    localparam int unsigned INFO_LSB       = 17;
    localparam int unsigned INPUT_TYPE_LSB = 14;
    localparam int unsigned BUF_BIT        = 13;
    localparam int unsigned MSG_W          = 13;

    localparam logic [3:0]       INFO_IDLE   = 4'b0000;
    localparam logic [3:0]       INFO_UPDATE = 4'b0001;
    localparam logic [3:0]       INFO_SWAP   = 4'b1111;
    localparam logic [CMD_W-1:0] IDLE_CMD    = 32'h0;

    localparam logic [1:0] ADDR_CMD    = 2'd0;
    localparam logic [1:0] ADDR_COMMIT = 2'd1;
    localparam logic [1:0] ADDR_CLR    = 2'd2;

    // One queue slot: marker=1 denotes a commit (buffer swap request).
    typedef struct packed {
        logic             marker;
        logic [CMD_W-1:0] word;
    } fifo_entry_t;

    // Software command stamped with the back buffer; a raw swap code is
    // neutralised so only the scheduler can ever issue a swap.
    function automatic logic [CMD_W-1:0] stamp_cmd(input logic [CMD_W-1:0] w,
                                                   input logic             bb);
        logic [3:0] info;
        info = w[INFO_MSB:INFO_LSB];
        if (info == INFO_SWAP) begin
            info = INFO_IDLE;
        end
        return {w[CMD_W-1:SUB_COMP_LSB], w[SUB_COMP_LSB-1:CHILD_LSB], info,
                w[INFO_LSB-1:INPUT_TYPE_LSB], bb, w[MSG_W-1:0]};
    endfunction

    // Swap command carrying the buffer index being handed to the display.
    function automatic logic [CMD_W-1:0] swap_cmd(input logic bb);
        logic [CMD_W-1:0] r;
        r                    = IDLE_CMD;
        r[INFO_MSB:INFO_LSB] = INFO_SWAP;
        r[BUF_BIT]           = bb;
        return r;
    endfunction

endpackage

// File: rtl/frame_cmd_scheduler_cmd_fifo.sv
// cmd_fifo: synchronous FIFO of fifo_entry_t with async active-high reset.
// Ports: clk, reset, push_i/push_data_i (enqueue), pop_i (dequeue),
// full_o, empty_o, level_o (occupancy), head_o (first-word fall-through).
module cmd_fifo
    import frame_cmd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push_i,
    input  fifo_entry_t                   push_data_i,
    input  logic                          pop_i,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output fifo_entry_t                   head_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    fifo_entry_t       mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;
    logic              push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Fullness is judged before the edge, so a same-cycle pop never admits a push.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Storage needs no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/frame_cmd_scheduler.sv
// frame_cmd_scheduler: queues Avalon command writes, stamps them with the
// back-buffer index and drives them onto the shared layer command bus;
// commits become one buffer swap per vertical blank.
// Ports: clk, reset (async, active-high); Avalon slave chipselect, write,
// read, address, writedata, readdata (status); vcount (VGA line);
// cmd_out (registered layer bus); back_buf (current back buffer).
module frame_cmd_scheduler
    import frame_cmd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 64,
    parameter logic [9:0]  V_ACTIVE   = 10'd480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [9:0]  vcount,
    output logic [31:0] cmd_out,
    output logic        back_buf
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             wr_cmd_c, wr_commit_c, wr_clr_c, push_c, pop_c, in_blank_c;
    fifo_entry_t      push_entry_c, head;
    logic             full, empty;
    logic [LVL_W-1:0] level;

    logic [31:0]      cmd_q, cmd_d;
    logic             bb_q, bb_d;
    logic             swapped_q, swapped_d;
    logic             ovf_q, ovf_d;
    logic [LVL_W-1:0] mcnt_q, mcnt_d;

    // Status is returned every cycle regardless of the read strobe.
    logic unused_read;
    assign unused_read = read;

    assign wr_cmd_c    = chipselect && write && (address == ADDR_CMD);
    assign wr_commit_c = chipselect && write && (address == ADDR_COMMIT);
    assign wr_clr_c    = chipselect && write && (address == ADDR_CLR);
    assign push_c      = wr_cmd_c || wr_commit_c;
    assign in_blank_c  = (vcount >= V_ACTIVE);

    assign push_entry_c.marker = wr_commit_c;
    assign push_entry_c.word   = wr_commit_c ? IDLE_CMD : writedata;

    cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_c),
        .push_data_i (push_entry_c),
        .pop_i       (pop_c),
        .full_o      (full),
        .empty_o     (empty),
        .level_o     (level),
        .head_o      (head)
    );

    // Drain decision, swap gating and status bookkeeping.
    always_comb begin
        pop_c     = 1'b0;
        cmd_d     = IDLE_CMD;
        bb_d      = bb_q;
        swapped_d = swapped_q;
        ovf_d     = ovf_q;
        mcnt_d    = mcnt_q;

        if (!in_blank_c) begin
            swapped_d = 1'b0;
        end

        if (!empty) begin
            if (!head.marker) begin
                pop_c = 1'b1;
                cmd_d = stamp_cmd(head.word, bb_q);
            end else if (in_blank_c && !swapped_q) begin
                // A marker blocks everything behind it until its swap goes out.
                pop_c     = 1'b1;
                cmd_d     = swap_cmd(bb_q);
                bb_d      = ~bb_q;
                swapped_d = 1'b1;
            end
        end

        if (push_c && full) begin
            ovf_d = 1'b1;
        end else if (wr_clr_c) begin
            ovf_d = 1'b0;
        end

        // Markers in flight, so commit_pending needs no FIFO scan.
        if ((wr_commit_c && !full) && !(pop_c && head.marker)) begin
            mcnt_d = mcnt_q + LVL_W'(1);
        end else if ((pop_c && head.marker) && !(wr_commit_c && !full)) begin
            mcnt_d = mcnt_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q     <= IDLE_CMD;
            bb_q      <= 1'b1;
            swapped_q <= 1'b0;
            ovf_q     <= 1'b0;
            mcnt_q    <= '0;
        end else begin
            cmd_q     <= cmd_d;
            bb_q      <= bb_d;
            swapped_q <= swapped_d;
            ovf_q     <= ovf_d;
            mcnt_q    <= mcnt_d;
        end
    end

    assign cmd_out  = cmd_q;
    assign back_buf = bb_q;
    assign readdata = {8'h0, 16'(level), 5'h0, ovf_q, (mcnt_q != '0), bb_q};

endmodule

// File: tb/tb_frame_cmd_scheduler.sv
// Directed self-checking bench for frame_cmd_scheduler.
module tb_frame_cmd_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect, write, read;
    logic [1:0]  address;
    logic [31:0] writedata, readdata, cmd_out;
    logic [9:0]  vcount;
    logic        back_buf;

    int checks = 0;
    int errors = 0;

    frame_cmd_scheduler #(
        .FIFO_DEPTH (64),
        .V_ACTIVE   (10'd480)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .vcount     (vcount),
        .cmd_out    (cmd_out),
        .back_buf   (back_buf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b1;
        address = 2'd0; writedata = 32'h0; vcount = 10'd100;
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_cmd", cmd_out, 32'h0);
        check("rst_status", readdata, 32'h0000_0001);

        // Single command: one-cycle latency, one-cycle pulse
        wr(2'd0, 32'h3C02_80C8);
        check("cmd_queued_status", readdata, 32'h0000_0101);
        check("cmd_not_yet", cmd_out, 32'h0);
        tick();
        check("cmd_out", cmd_out, 32'h3C02_A0C8);
        check("cmd_drained_status", readdata, 32'h0000_0001);
        tick();
        check("cmd_idle", cmd_out, 32'h0);

        // Commit waits for vertical blank
        wr(2'd1, 32'hFFFF_FFFF);
        check("commit_pending", readdata, 32'h0000_0103);
        tick();
        check("commit_hold", cmd_out, 32'h0);
        vcount = 10'd480;
        tick();
        check("swap_word", cmd_out, 32'h001E_2000);
        check("swap_status", readdata, 32'h0000_0000);
        check("swap_back_buf", {31'h0, back_buf}, 32'h0);
        tick();
        check("swap_pulse", cmd_out, 32'h0);
        vcount = 10'd100;
        tick();

        // Commit then command: command stays behind the swap
        do_reset();
        wr(2'd1, 32'h0);
        wr(2'd0, 32'h3C02_80C8);
        tick();
        check("blocked_cmd", cmd_out, 32'h0);
        check("blocked_status", readdata, 32'h0000_0203);
        vcount = 10'd480;
        tick();
        check("swap_first", cmd_out, 32'h001E_2000);
        tick();
        check("cmd_after_swap", cmd_out, 32'h3C02_80C8);
        tick();
        check("after_swap_idle", cmd_out, 32'h0);
        vcount = 10'd100;
        tick();

        // Async reset discards queued work, including a commit
        do_reset();
        wr(2'd1, 32'h0);
        wr(2'd0, 32'h3C02_80C8);
        check("pre_reset_status", readdata, 32'h0000_0203);
        reset = 1'b1;
        #1;
        check("async_reset_status", readdata, 32'h0000_0001);
        tick();
        reset = 1'b0;
        vcount = 10'd480;
        tick();
        tick();
        check("no_swap_after_reset", cmd_out, 32'h0);
        check("no_swap_status", readdata, 32'h0000_0001);
        vcount = 10'd100;
        tick();

        // Two commits: one swap per blank
        wr(2'd1, 32'h0);
        wr(2'd1, 32'h0);
        check("two_commits_status", readdata, 32'h0000_0203);
        vcount = 10'd480;
        tick();
        check("swap_a", cmd_out, 32'h001E_2000);
        tick();
        check("second_held", cmd_out, 32'h0);
        check("second_held_status", readdata, 32'h0000_0102);
        tick();
        check("second_still_held", cmd_out, 32'h0);
        vcount = 10'd100;
        tick();
        check("active_idle", cmd_out, 32'h0);
        vcount = 10'd480;
        tick();
        check("swap_b", cmd_out, 32'h001E_0000);
        check("swap_b_status", readdata, 32'h0000_0001);
        tick();
        check("swap_b_pulse", cmd_out, 32'h0);
        vcount = 10'd100;
        tick();

        // Overflow: commit blocks the queue, 64th command is dropped
        wr(2'd1, 32'h0);
        for (int i = 0; i < 64; i++) begin
            wr(2'd0, 32'h3C02_0000 | 32'(i));
        end
        check("full_status", readdata, 32'h0000_4007);
        wr(2'd3, 32'hFFFF_FFFF);
        check("addr3_ignored", readdata, 32'h0000_4007);
        wr(2'd2, 32'h0);
        check("ovf_cleared", readdata, 32'h0000_4003);
        vcount = 10'd480;
        tick();
        check("full_swap", cmd_out, 32'h001E_2000);
        for (int i = 0; i < 63; i++) begin
            tick();
            check("drain_word", cmd_out, 32'h3C02_0000 | 32'(i));
        end
        tick();
        check("dropped_not_seen", cmd_out, 32'h0);
        check("drained_status", readdata, 32'h0000_0000);
        vcount = 10'd100;
        tick();

        // Swap code neutralised, buffer bit overwritten, push+pop keeps level
        wr(2'd0, 32'h843E_8005);
        wr(2'd0, 32'h3C02_20C8);
        check("info_swap_masked", cmd_out, 32'h8420_8005);
        check("push_pop_level", readdata, 32'h0000_0100);
        tick();
        check("buf_bit_stamped", cmd_out, 32'h3C02_00C8);
        check("final_status", readdata, 32'h0000_0000);
        tick();
        check("final_idle", cmd_out, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
